// File: rtl/knn_sort_controller.sv
// knn_sort_controller: streams beats of labelled distances through a bitonic
// network and keeps the K smallest words of the current query.
module knn_bitonic_sorter #(
    parameter int                     REGISTER_SIZE = 12,
    parameter int                     K             = 5,
    parameter int                     N             = 4,
    parameter logic [REGISTER_SIZE-1:0] PAD         = '1
) (
    input  logic [K*REGISTER_SIZE-1:0] i_kept,
    input  logic [N*REGISTER_SIZE-1:0] i_new,
    output logic [K*REGISTER_SIZE-1:0] o_smallest
);
    localparam int W  = 2 ** $clog2(K + N);
    localparam int LW = $clog2(W);
    logic [W*REGISTER_SIZE-1:0] flat;
    logic [REGISTER_SIZE-1:0]   init [W];
    logic [REGISTER_SIZE-1:0]   s    [W];
    assign flat = {{(W - K - N){PAD}}, i_new, i_kept};
    for (genvar e = 0; e < W; e++) begin : g_init
        assign init[e] = flat[e*REGISTER_SIZE +: REGISTER_SIZE];
    end
    for (genvar e = 0; e < K; e++) begin : g_out
        assign o_smallest[e*REGISTER_SIZE +: REGISTER_SIZE] = s[e];
    end
    // Full ascending bitonic sort on the distance field; the label bit rides along.
    always_comb begin
        logic [REGISTER_SIZE-1:0] t;
        t = '0;
        s = init;
        for (int k = 2; k <= W; k = k * 2) begin
            for (int j = k / 2; j > 0; j = j / 2) begin
                for (int i = 0; i < W; i++) begin
                    if ((i ^ j) > i && ((s[LW'(i)][REGISTER_SIZE-2:0] > s[LW'(i ^ j)][REGISTER_SIZE-2:0]) == ((i & k) == 0))) begin
                        t = s[LW'(i)];
                        s[LW'(i)] = s[LW'(i ^ j)];
                        s[LW'(i ^ j)] = t;
                    end
                end
            end
        end
    end
endmodule

module knn_sort_controller #(
    parameter int                       REGISTER_SIZE               = 12,
    parameter int                       K                           = 5,
    parameter int                       NUM_OF_DISTANCE_CALCULATORS = 4,
    parameter logic [REGISTER_SIZE-1:0] RST_VALUE                   = 12'd4095
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              i_start,
    input  logic [15:0]                                       i_num_groups,
    input  logic                                              i_data_valid,
    input  logic [NUM_OF_DISTANCE_CALCULATORS*REGISTER_SIZE-1:0] i_data,
    input  logic [NUM_OF_DISTANCE_CALCULATORS-1:0]            i_data_mask,
    output logic                                              o_data_ready,
    output logic [K*REGISTER_SIZE-1:0]                        o_sorted,
    output logic [K-1:0]                                      o_group_bits,
    output logic                                              o_busy,
    output logic                                              o_done
);
    localparam int N = NUM_OF_DISTANCE_CALCULATORS;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [15:0]              remaining_q, remaining_d;
    logic                     data_valid_q, data_valid_d;
    logic [N*REGISTER_SIZE-1:0] data_q, data_d, masked;
    logic [K*REGISTER_SIZE-1:0] smallest_q, smallest_d, sorted;
    logic                     accept;

    knn_bitonic_sorter #(
        .REGISTER_SIZE(REGISTER_SIZE),
        .K            (K),
        .N            (N),
        .PAD          (RST_VALUE)
    ) u_sorter (
        .i_kept    (smallest_q),
        .i_new     (data_q),
        .o_smallest(sorted)
    );

    for (genvar e = 0; e < N; e++) begin : g_mask
        assign masked[e*REGISTER_SIZE +: REGISTER_SIZE] = i_data_mask[e] ? i_data[e*REGISTER_SIZE +: REGISTER_SIZE] : RST_VALUE;
    end
    for (genvar e = 0; e < K; e++) begin : g_group
        assign o_group_bits[K-1-e] = smallest_q[e*REGISTER_SIZE + REGISTER_SIZE - 1];
    end

    assign o_data_ready = state_q == RUN;
    assign o_busy       = state_q != IDLE;
    assign o_done       = state_q == DONE;
    assign o_sorted     = smallest_q;
    assign accept       = i_data_valid & o_data_ready;

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        data_valid_d = 1'b0;
        data_d       = data_q;
        smallest_d   = data_valid_q ? sorted : smallest_q;
        case (state_q)
            IDLE: if (i_start) begin
                smallest_d  = {K{RST_VALUE}};
                remaining_d = i_num_groups;
                state_d     = i_num_groups == 16'd0 ? DONE : RUN;
            end
            RUN: if (accept) begin
                data_d       = masked;
                data_valid_d = 1'b1;
                remaining_d  = remaining_q - {15'd0, remaining_q != 16'd0};
                state_d      = remaining_q <= 16'd1 ? DRAIN : RUN;
            end
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            data_valid_q <= 1'b0;
            data_q       <= {N{RST_VALUE}};
            smallest_q   <= {K{RST_VALUE}};
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
            smallest_q   <= smallest_d;
        end
    end
endmodule
